rd_arbiter: RTL and testbench
=============================

Name: rd_arbiter

Overview:
- Round-robin arbiter that shares one downstream read-handshake unit (rd in; rd_data, ack out) among N requesters.
- Serialises requests, drives the shared rd line and routes the returned ack to the winner as a one-cycle done pulse.
- Drops rd for one cycle after every transaction so the downstream unit returns to its idle state.
- Aborts with an error pulse if ack does not arrive within TIMEOUT cycles.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 15, maximum cycles in BUSY waiting for ack (>=3).
- CW, 4, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  per-requester request level; held high until done or err.
- grant  output  N  one-hot, registered; identifies the current owner.
- done  output  N  one-cycle pulse to the owner when ack is received.
- err  output  1  one-cycle pulse on timeout abort.
- busy  output  1  high in BUSY.
- rd  output  1  to downstream unit; registered.
- rd_data_in  input  1  from downstream rd_data.
- ack_in  input  1  from downstream ack.
- rd_data_out  output  1  rd_data_in AND busy (combinational pass-through).

Behaviour:
- Reset state: IDLE; grant=0, done=0, err=0, busy=0, rd=0, counter=0, last-grant pointer=N-1 (requester 0 wins first).
- State encoding: IDLE, BUSY, RELEASE.
- IDLE:
  - If any req bit is high, the winner is the first requester with req high, searching upward from pointer+1 modulo N.
  - At the next edge: grant=onehot(winner), rd=1, busy=1, pointer=winner, counter=0, state goes to BUSY.
  - With no req, state stays IDLE and all outputs are 0.
- BUSY:
  - rd and grant are held; the counter increments each cycle.
  - Priority order, evaluated at each edge:
    1. req[owner]=0: abort. Go to RELEASE; no done, no err.
    2. ack_in=1: pulse done[owner] for one cycle; go to RELEASE.
    3. counter==TIMEOUT-1: pulse err for one cycle; go to RELEASE.
  - ack_in and timeout in the same cycle: ack wins, so done pulses and err does not.
- RELEASE:
  - Lasts exactly one cycle with rd=0, grant=0, busy=0; then IDLE.
  - Requests arriving during RELEASE are not evaluated until IDLE.
- Latency with a compliant downstream unit (IDLE->READ->ACK_NOW on consecutive edges while rd=1):
  - req high before edge E0 gives rd/grant high after E0.
  - ack_in is high after E2 and sampled at E3.
  - done pulses in the cycle after E3; rd is low after E3.
  - Back-to-back grants are therefore 2 cycles apart after done (RELEASE, IDLE).
- done and err are registered pulses, never high for more than one cycle.
- At most one grant bit is high at any time.
- req changes of non-owners during BUSY are ignored.
- The pointer advances only on grant, never on abort alone.
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronously). The pointer returns to N-1 and no done or err is issued.
- ack_in high in IDLE or RELEASE is ignored.
- rd_data_out is forced to 0 outside BUSY.

Test Plan:
- Single request: req=4'b0001 held, downstream model attached → grant=0001 and rd=1 at E0, done[0] pulse at E3+, rd=0 for one RELEASE cycle, then IDLE.
- Round-robin: req=4'b1111 held, requesters drop req after their done → grant sequence 0001, 0010, 0100, 1000, 0001; each done goes only to the owner.
- Timeout: ack_in tied 0, req=4'b0100 → rd high for exactly 15 cycles, err pulse once, done=0, then RELEASE and IDLE; pointer=2, so requester 3 wins next.
- Abort: req[1] drops one cycle after grant=0010 → RELEASE next edge, no done, no err, rd=0.
- Simultaneous ack and timeout in the final BUSY cycle → done pulse, err stays 0.
- Reset mid-BUSY: rst pulsed while grant=1000 → grant, rd and busy go to 0 without waiting for clk; after release, req=4'b1001 → requester 0 granted first.

Source files
------------

// File: rtl/rd_arbiter.sv
// rd_arbiter: round-robin arbiter sharing one downstream read-handshake unit
// among N requesters. Serialises requests onto a single rd line, routes the
// returned ack to the owner as a done pulse, and aborts with err when ack
// fails to arrive within TIMEOUT cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; pick the next requester round-robin from ptr+1
// BUSY    | rd/grant held for the owner; waiting for ack, abort or timeout
// RELEASE | one cycle with rd low so the downstream unit returns to idle
module rd_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [N-1:0] done,
  output logic         err,
  output logic         busy,
  output logic         rd,
  input  logic         rd_data_in,
  input  logic         ack_in,
  output logic         rd_data_out
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;
  logic            err_q, err_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx_pw;

  // Round-robin search: first requester with req high, starting at ptr+1.
  always_comb begin
    found  = 1'b0;
    win    = ptr_q;
    idx_pw = '0;
    for (int i = 1; i <= N; i++) begin
      idx_pw = PW'((int'(ptr_q) + i) % N);
      if (!found && req[idx_pw]) begin
        found = 1'b1;
        win   = idx_pw;
      end
    end
  end

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
        if (found) begin
          state_d = S_BUSY;
          grant_d = ONE << win;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = win;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Owner withdrawal beats ack, and ack beats timeout on the same edge.
        if (!req[ptr_q] || ack_in || (cnt_q == CNT_LAST)) begin
          state_d = S_RELEASE;
          grant_d = '0;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (req[ptr_q]) begin
            if (ack_in) done_d = ONE << ptr_q;
            else        err_d  = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        grant_d = '0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything and rewinds the
  // pointer so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign rd          = rd_q;
  assign rd_data_out = rd_data_in & busy_q;

endmodule

// File: tb/tb_rd_arbiter.sv
// Testbench for rd_arbiter: directed and randomized transactions checked
// against a transaction-level model (round-robin pick plus outcome timing
// computed as the earliest of abort, ack and timeout).
module tb_rd_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         err;
  logic         busy;
  logic         rd;
  logic         rd_data_in;
  logic         ack_in;
  logic         rd_data_out;

  int checks = 0;
  int errors = 0;
  int mptr   = N - 1;

  rd_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .rd          (rd),
    .rd_data_in  (rd_data_in),
    .ack_in      (ack_in),
    .rd_data_out (rd_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] one;
    one = 1;
    return one << w;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk_all(input string tag, input logic [N-1:0] eg, input logic er,
                         input logic [N-1:0] ed, input logic ee);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".rd"},    32'(rd),    32'(er));
    chk({tag, ".busy"},  32'(busy),  32'(er));
    chk({tag, ".done"},  32'(done),  32'(ed));
    chk({tag, ".err"},   32'(err),   32'(ee));
    chk({tag, ".rdout"}, 32'(rd_data_out), 32'(rd_data_in & er));
  endtask

  // One transaction starting from IDLE. delay: ack_in goes high once the
  // owner has seen rd for delay edges (sampled at edge delay+1).
  // abort_k: edge at which req[owner] is first sampled low (0 = never).
  task automatic txn(input string tag, input logic [N-1:0] reqv, input int delay,
                     input int abort_k);
    int w, endk, kind, a, d;
    logic [N-1:0] nreq;
    w = pick(reqv, mptr);
    a = (abort_k > 0) ? abort_k : 1000;
    d = delay + 1;
    if (a <= d && a <= TIMEOUT) begin endk = a; kind = 0; end
    else if (d <= TIMEOUT)      begin endk = d; kind = 1; end
    else                        begin endk = TIMEOUT; kind = 2; end

    @(negedge clk);
    req        = reqv;
    ack_in     = 1'($urandom);
    rd_data_in = 1'($urandom);
    @(posedge clk); #1;
    mptr = w;
    chk_all({tag, ".grant0"}, oh(w), 1'b1, '0, 1'b0);

    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      nreq       = N'($urandom);
      nreq[w]    = !(abort_k > 0 && k >= abort_k);
      req        = nreq;
      ack_in     = (k == d);
      rd_data_in = 1'($urandom);
      @(posedge clk); #1;
      if (k < endk)
        chk_all({tag, ".busy"}, oh(w), 1'b1, '0, 1'b0);
      else
        chk_all({tag, ".end"}, '0, 1'b0, (kind == 1) ? oh(w) : '0, kind == 2);
    end

    // RELEASE: requests and ack are not evaluated here.
    @(negedge clk);
    req        = N'($urandom);
    ack_in     = 1'($urandom);
    rd_data_in = 1'($urandom);
    @(posedge clk); #1;
    chk_all({tag, ".idle"}, '0, 1'b0, '0, 1'b0);
    req    = '0;
    ack_in = 1'b0;
  endtask

  initial begin
    int delay, abort_k, sel;
    req        = '0;
    ack_in     = 1'b0;
    rd_data_in = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mptr = N - 1;

    // ack high in IDLE with no request is ignored
    ack_in = 1'b1;
    @(posedge clk); #1;
    chk_all("idle_ack", '0, 1'b0, '0, 1'b0);
    ack_in = 1'b0;

    txn("single", 4'b0001, 2, 0);
    for (int i = 0; i < 5; i++) txn("rr", 4'b1111, 2, 0);
    txn("timeout", 4'b0100, 100, 0);
    txn("after_to", 4'b1111, 2, 0);
    chk("after_to.ptr", 32'(mptr), 32'd3);
    txn("abort", 4'b0010, 2, 1);
    txn("abort_tie", 4'b0001, 4, 5);
    txn("ack_at_to", 4'b1000, TIMEOUT - 1, 0);
    txn("ack_late", 4'b0010, TIMEOUT, 0);

    // Reset asserted mid-BUSY while requester 3 owns the bus
    @(negedge clk);
    req = 4'b1000;
    @(posedge clk); #1;
    chk("rst_mid.grant_pre", 32'(grant), 32'(4'b1000));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_all("rst_mid", '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    mptr = N - 1;
    req  = 4'b1001;
    @(posedge clk); #1;
    chk_all("rst_after", oh(0), 1'b1, '0, 1'b0);
    mptr = 0;
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    chk_all("rst_after_abort", '0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_after_idle", '0, 1'b0, '0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       delay = 2;
        1:       delay = $urandom_range(2, TIMEOUT + 1);
        2:       delay = TIMEOUT - 1;
        default: delay = TIMEOUT + 5;
      endcase
      abort_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      txn("rand", N'($urandom_range(1, (1 << N) - 1)), delay, abort_k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
